// File: rtl/de_pkg.sv
// de_pkg: shared types and constants for the RV32I decode stage.
//   - latch widths and the DE latch field offsets (AGEX slices the same bus)
//   - op_e: 6-bit decoded operation, OP_INVALID for anything unrecognised
//   - RV32I opcode / funct3 / funct7 encodings used by the decoder
//   - fe_latch_t / de_latch_t: packed views of the fetch and DE latches
package de_pkg;

  localparam int DBITS      = 32;
  localparam int REGNO      = 32;
  localparam int REGBITS    = 5;
  localparam int SB_BITS    = 2;
  localparam int FE_LATCH_W = 129;
  localparam int DE_LATCH_W = 205;

  localparam logic [SB_BITS-1:0] SB_ZERO = 2'd0;
  localparam logic [SB_BITS-1:0] SB_ONE  = 2'd1;
  localparam logic [SB_BITS-1:0] SB_MAX  = 2'd3;

  // DE latch bit offsets (LSB of each field), MSB-first order
  localparam int DE_VALID_BIT  = 204;
  localparam int DE_OP_LSB     = 198;
  localparam int DE_WR_EN_BIT  = 197;
  localparam int DE_RD_LSB     = 192;
  localparam int DE_RS1VAL_LSB = 160;
  localparam int DE_RS2VAL_LSB = 128;
  localparam int DE_IMM_LSB    = 96;
  localparam int DE_PC_LSB     = 64;
  localparam int DE_PCPLUS_LSB = 32;
  localparam int DE_ICNT_LSB   = 0;

  typedef enum logic [5:0] {
    OP_INVALID = 6'd0,
    OP_LUI     = 6'd1,
    OP_AUIPC   = 6'd2,
    OP_JAL     = 6'd3,
    OP_JALR    = 6'd4,
    OP_BEQ     = 6'd5,
    OP_BNE     = 6'd6,
    OP_BLT     = 6'd7,
    OP_BGE     = 6'd8,
    OP_BLTU    = 6'd9,
    OP_BGEU    = 6'd10,
    OP_LW      = 6'd11,
    OP_SW      = 6'd12,
    OP_ADDI    = 6'd13,
    OP_SLTI    = 6'd14,
    OP_SLTIU   = 6'd15,
    OP_XORI    = 6'd16,
    OP_ORI     = 6'd17,
    OP_ANDI    = 6'd18,
    OP_SLLI    = 6'd19,
    OP_SRLI    = 6'd20,
    OP_SRAI    = 6'd21,
    OP_ADD     = 6'd22,
    OP_SUB     = 6'd23,
    OP_SLL     = 6'd24,
    OP_SLT     = 6'd25,
    OP_SLTU    = 6'd26,
    OP_XOR     = 6'd27,
    OP_SRL     = 6'd28,
    OP_SRA     = 6'd29,
    OP_OR      = 6'd30,
    OP_AND     = 6'd31
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic             valid;
    logic [DBITS-1:0] inst;
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] pcplus;
    logic [DBITS-1:0] inst_count;
  } fe_latch_t;

  typedef struct packed {
    logic               valid;
    op_e                op;
    logic               wr_en;
    logic [REGBITS-1:0] rd;
    logic [DBITS-1:0]   rs1val;
    logic [DBITS-1:0]   rs2val;
    logic [DBITS-1:0]   imm;
    logic [DBITS-1:0]   pc;
    logic [DBITS-1:0]   pcplus;
    logic [DBITS-1:0]   inst_count;
  } de_latch_t;

endpackage

// File: rtl/de_regfile.sv
// de_regfile: 32x32 register file, 2 read / 1 write.
//   clk, rst_n       : clock, asynchronous active-low reset (clears x1..x31)
//   ra1/ra2, rd1/rd2 : combinational read ports; x0 reads 0, a same-cycle
//                      write to the read address is forwarded (write-through)
//   we, wa, wd       : write port, committed on the rising edge when wa != 0
module de_regfile
  import de_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REGBITS-1:0] ra1,
  input  logic [REGBITS-1:0] ra2,
  output logic [DBITS-1:0]   rd1,
  output logic [DBITS-1:0]   rd2,
  input  logic               we,
  input  logic [REGBITS-1:0] wa,
  input  logic [DBITS-1:0]   wd
);

  logic [DBITS-1:0] regs_q [REGNO];
  logic [DBITS-1:0] regs_d [REGNO];

  // next register contents; entry 0 is pinned to zero
  always_comb begin
    for (int r = 0; r < REGNO; r++) begin
      regs_d[r] = (we && (wa == REGBITS'(r)) && (r != 0)) ? wd : regs_q[r];
    end
    regs_d[0] = '0;
  end

  // register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REGNO; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REGNO; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // read ports with write-through forwarding
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : ((we && (wa == ra1)) ? wd : regs_q[ra1]);
    rd2 = (ra2 == 5'd0) ? 32'd0 : ((we && (wa == ra2)) ? wd : regs_q[ra2]);
  end

endmodule

// File: rtl/de_stage_chk.sv
// de_stage_chk: scoreboard sanity checks for de_stage (simulation only).
//   clk, rst_n : clock, active-low reset (checks idle while in reset)
//   sb_q       : current per-register pending-write counters
//   sb_inc     : per-register increment request this cycle
//   sb_dec     : per-register decrement request this cycle
module de_stage_chk
  import de_pkg::*;
(
  input logic                            clk,
  input logic                            rst_n,
  input logic [REGNO-1:0][SB_BITS-1:0]   sb_q,
  input logic [REGNO-1:0]                sb_inc,
  input logic [REGNO-1:0]                sb_dec
);

  // a lone increment at max or a lone decrement at zero means the pipeline lost track
  always @(posedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < REGNO; r++) begin
        assert (!(sb_inc[r] && !sb_dec[r] && (sb_q[r] == SB_MAX)))
          else $error("scoreboard overflow on x%0d", r);
        assert (!(sb_dec[r] && !sb_inc[r] && (sb_q[r] == SB_ZERO)))
          else $error("scoreboard underflow on x%0d", r);
      end
    end
  end

endmodule

// File: rtl/de_stage.sv
// de_stage: RV32I decode stage.
//   clk           : clock
//   reset         : asynchronous active-low reset
//   fe_latch_in   : {valid, inst, pc, pcplus, inst_count} from fetch
//   agex_flush    : AGEX redirect this cycle; squashes this and the next input
//   wb_wr_en/reg/data : writeback port into the register file
//   stall_to_fe   : RAW hazard, fetch must hold (combinational)
//   de_latch_out  : registered {valid, op, wr_en, rd, rs1val, rs2val, imm,
//                   pc, pcplus, inst_count} toward AGEX
// Optional build macro DE_STALL_STATS_EN adds perf_stall_cnt and
// perf_squash_cnt (32-bit wrapping counters).
module de_stage
  import de_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FE_LATCH_W-1:0] fe_latch_in,
  input  logic                  agex_flush,
  input  logic                  wb_wr_en,
  input  logic [REGBITS-1:0]    wb_wr_reg,
  input  logic [DBITS-1:0]      wb_wr_data,
  output logic                  stall_to_fe,
  output logic [DE_LATCH_W-1:0] de_latch_out
`ifdef DE_STALL_STATS_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_squash_cnt
`endif
);

  fe_latch_t fe_s;
  assign fe_s = fe_latch_in;

  logic [6:0]         opcode_s;
  logic [2:0]         funct3_s;
  logic [6:0]         funct7_s;
  logic [REGBITS-1:0] rd_s, rs1_s, rs2_s;
  logic [DBITS-1:0]   imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

  assign opcode_s = fe_s.inst[6:0];
  assign rd_s     = fe_s.inst[11:7];
  assign funct3_s = fe_s.inst[14:12];
  assign rs1_s    = fe_s.inst[19:15];
  assign rs2_s    = fe_s.inst[24:20];
  assign funct7_s = fe_s.inst[31:25];

  assign imm_i_s = {{20{fe_s.inst[31]}}, fe_s.inst[31:20]};
  assign imm_s_s = {{20{fe_s.inst[31]}}, fe_s.inst[31:25], fe_s.inst[11:7]};
  assign imm_b_s = {{19{fe_s.inst[31]}}, fe_s.inst[31], fe_s.inst[7],
                    fe_s.inst[30:25], fe_s.inst[11:8], 1'b0};
  assign imm_u_s = {fe_s.inst[31:12], 12'd0};
  assign imm_j_s = {{11{fe_s.inst[31]}}, fe_s.inst[31], fe_s.inst[19:12],
                    fe_s.inst[20], fe_s.inst[30:21], 1'b0};

  op_e              op_s;
  logic             wr_fmt_s, use_rs1_s, use_rs2_s, wr_en_s;
  logic [DBITS-1:0] imm_s;

  // opcode/funct3/funct7 -> operation
  always_comb begin
    op_s = OP_INVALID;
    case (opcode_s)
      OPC_LUI:    op_s = OP_LUI;
      OPC_AUIPC:  op_s = OP_AUIPC;
      OPC_JAL:    op_s = OP_JAL;
      OPC_JALR:   op_s = (funct3_s == 3'b000) ? OP_JALR : OP_INVALID;
      OPC_BRANCH: begin
        case (funct3_s)
          F3_BEQ:  op_s = OP_BEQ;
          F3_BNE:  op_s = OP_BNE;
          F3_BLT:  op_s = OP_BLT;
          F3_BGE:  op_s = OP_BGE;
          F3_BLTU: op_s = OP_BLTU;
          F3_BGEU: op_s = OP_BGEU;
          default: op_s = OP_INVALID;
        endcase
      end
      OPC_LOAD:   op_s = (funct3_s == F3_W) ? OP_LW : OP_INVALID;
      OPC_STORE:  op_s = (funct3_s == F3_W) ? OP_SW : OP_INVALID;
      OPC_OPIMM: begin
        case (funct3_s)
          F3_ADD:  op_s = OP_ADDI;
          F3_SLT:  op_s = OP_SLTI;
          F3_SLTU: op_s = OP_SLTIU;
          F3_XOR:  op_s = OP_XORI;
          F3_OR:   op_s = OP_ORI;
          F3_AND:  op_s = OP_ANDI;
          F3_SLL:  op_s = (funct7_s == F7_BASE) ? OP_SLLI : OP_INVALID;
          F3_SR:   op_s = (funct7_s == F7_BASE) ? OP_SRLI :
                          ((funct7_s == F7_ALT) ? OP_SRAI : OP_INVALID);
          default: op_s = OP_INVALID;
        endcase
      end
      OPC_OP: begin
        case ({funct7_s, funct3_s})
          {F7_BASE, F3_ADD}:  op_s = OP_ADD;
          {F7_ALT,  F3_ADD}:  op_s = OP_SUB;
          {F7_BASE, F3_SLL}:  op_s = OP_SLL;
          {F7_BASE, F3_SLT}:  op_s = OP_SLT;
          {F7_BASE, F3_SLTU}: op_s = OP_SLTU;
          {F7_BASE, F3_XOR}:  op_s = OP_XOR;
          {F7_BASE, F3_SR}:   op_s = OP_SRL;
          {F7_ALT,  F3_SR}:   op_s = OP_SRA;
          {F7_BASE, F3_OR}:   op_s = OP_OR;
          {F7_BASE, F3_AND}:  op_s = OP_AND;
          default:            op_s = OP_INVALID;
        endcase
      end
      default: op_s = OP_INVALID;
    endcase
  end

  // operation -> format: immediate, sources used, writes rd
  always_comb begin
    wr_fmt_s  = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    imm_s     = 32'd0;
    case (op_s)
      OP_LUI, OP_AUIPC: begin
        wr_fmt_s = 1'b1;
        imm_s    = imm_u_s;
      end
      OP_JAL: begin
        wr_fmt_s = 1'b1;
        imm_s    = imm_j_s;
      end
      OP_JALR, OP_LW, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI: begin
        wr_fmt_s  = 1'b1;
        use_rs1_s = 1'b1;
        imm_s     = imm_i_s;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm_s     = imm_b_s;
      end
      OP_SW: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm_s     = imm_s_s;
      end
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
      OP_OR, OP_AND: begin
        wr_fmt_s  = 1'b1;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      default: begin
        wr_fmt_s = 1'b0;
      end
    endcase
  end

  assign wr_en_s = wr_fmt_s && (rd_s != 5'd0);

  logic [DBITS-1:0] rd1_s, rd2_s;

  de_regfile u_regfile (
    .clk   (clk),
    .rst_n (reset),
    .ra1   (rs1_s),
    .ra2   (rs2_s),
    .rd1   (rd1_s),
    .rd2   (rd2_s),
    .we    (wb_wr_en),
    .wa    (wb_wr_reg),
    .wd    (wb_wr_data)
  );

  logic [REGNO-1:0][SB_BITS-1:0] sb_q, sb_d;
  logic [REGNO-1:0]              sb_inc_s, sb_dec_s;
  logic                          kill_q, kill_d;
  logic                          live_s, hz1_s, hz2_s, hazard_s, fire_s;

  // RAW hazard: a pending write is only cleared early by a WB of the last outstanding write.
  // Squashed inputs (flush or kill) never stall so the redirect is not held up.
  always_comb begin
    live_s   = fe_s.valid && !agex_flush && !kill_q;
    hz1_s    = use_rs1_s && (sb_q[rs1_s] != SB_ZERO) &&
               !(wb_wr_en && (wb_wr_reg == rs1_s) && (sb_q[rs1_s] == SB_ONE));
    hz2_s    = use_rs2_s && (sb_q[rs2_s] != SB_ZERO) &&
               !(wb_wr_en && (wb_wr_reg == rs2_s) && (sb_q[rs2_s] == SB_ONE));
    hazard_s = live_s && (hz1_s || hz2_s);
    fire_s   = live_s && !hazard_s;
  end

  assign stall_to_fe = hazard_s;

  // scoreboard next state, saturating both ways
  always_comb begin
    for (int r = 0; r < REGNO; r++) begin
      sb_inc_s[r] = fire_s && wr_en_s && (rd_s == REGBITS'(r));
      sb_dec_s[r] = wb_wr_en && (wb_wr_reg == REGBITS'(r)) && (r != 0);
      case ({sb_inc_s[r], sb_dec_s[r]})
        2'b10:   sb_d[r] = (sb_q[r] == SB_MAX)  ? sb_q[r] : sb_q[r] + SB_ONE;
        2'b01:   sb_d[r] = (sb_q[r] == SB_ZERO) ? sb_q[r] : sb_q[r] - SB_ONE;
        default: sb_d[r] = sb_q[r];
      endcase
    end
    sb_d[0] = SB_ZERO;
  end

  // the redirect edge lets one old-path fetch through, so kill covers the next cycle
  always_comb begin
    kill_d = agex_flush;
  end

  de_latch_t de_latch_q, de_latch_d;

  // DE latch contents: a decoded bundle when firing, otherwise a bubble
  always_comb begin
    de_latch_d = fire_s ? de_latch_t'{
      valid:      1'b1,
      op:         op_s,
      wr_en:      wr_en_s,
      rd:         rd_s,
      rs1val:     use_rs1_s ? rd1_s : 32'd0,
      rs2val:     use_rs2_s ? rd2_s : 32'd0,
      imm:        imm_s,
      pc:         fe_s.pc,
      pcplus:     fe_s.pcplus,
      inst_count: fe_s.inst_count
    } : de_latch_t'('0);
  end

  // stage state: scoreboard, kill flag, DE latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_q       <= '0;
      kill_q     <= 1'b0;
      de_latch_q <= '0;
    end else begin
      sb_q       <= sb_d;
      kill_q     <= kill_d;
      de_latch_q <= de_latch_d;
    end
  end

  assign de_latch_out = de_latch_q;

  de_stage_chk u_chk (
    .clk    (clk),
    .rst_n  (reset),
    .sb_q   (sb_q),
    .sb_inc (sb_inc_s),
    .sb_dec (sb_dec_s)
  );

`ifdef DE_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, squash_cnt_q, squash_cnt_d;

  // performance counters, wrapping naturally at 2^32
  always_comb begin
    stall_cnt_d  = stall_cnt_q + (hazard_s ? 32'd1 : 32'd0);
    squash_cnt_d = squash_cnt_q +
                   ((fe_s.valid && (agex_flush || kill_q)) ? 32'd1 : 32'd0);
  end

  // performance counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_de_stage.sv
// Directed bench for de_stage: reset, RAW stall/release, flush/kill, x0
// destination, branch immediate, simultaneous scoreboard inc/dec, invalid op.
module tb_de_stage;
  import de_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [FE_LATCH_W-1:0] fe_latch_in;
  logic                  agex_flush;
  logic                  wb_wr_en;
  logic [REGBITS-1:0]    wb_wr_reg;
  logic [DBITS-1:0]      wb_wr_data;
  logic                  stall_to_fe;
  logic [DE_LATCH_W-1:0] de_latch_out;

  int total = 0;
  int bad   = 0;

  de_stage dut (
    .clk          (clk),
    .reset        (reset),
    .fe_latch_in  (fe_latch_in),
    .agex_flush   (agex_flush),
    .wb_wr_en     (wb_wr_en),
    .wb_wr_reg    (wb_wr_reg),
    .wb_wr_data   (wb_wr_data),
    .stall_to_fe  (stall_to_fe),
    .de_latch_out (de_latch_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DE_LATCH_W-1:0] obs,
                     input logic [DE_LATCH_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] cnt);
    fe_latch_in = {1'b1, inst, pc, pc + 32'd4, cnt};
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_wr_en   = en;
    wb_wr_reg  = r;
    wb_wr_data = d;
  endtask

  function automatic de_latch_t mk(input op_e op, input logic wr, input logic [4:0] rd,
                                   input logic [31:0] v1, input logic [31:0] v2,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input logic [31:0] cnt);
    de_latch_t e;
    e.valid = 1'b1; e.op = op; e.wr_en = wr; e.rd = rd;
    e.rs1val = v1; e.rs2val = v2; e.imm = imm;
    e.pc = pc; e.pcplus = pc + 32'd4; e.inst_count = cnt;
    return e;
  endfunction

  localparam logic [31:0] I_ADDI_X1_5  = 32'h00500093;
  localparam logic [31:0] I_ADD_X2_X1  = 32'h00108133;
  localparam logic [31:0] I_ADD_X3_X2  = 32'h000101B3;
  localparam logic [31:0] I_ADDI_X0_1  = 32'h00100013;
  localparam logic [31:0] I_ADD_X3_X0  = 32'h000001B3;
  localparam logic [31:0] I_BEQ_M4     = 32'hFE000EE3;
  localparam logic [31:0] I_ADDI_X5_7  = 32'h00700293;
  localparam logic [31:0] I_ADDI_X5_9  = 32'h00900293;
  localparam logic [31:0] I_ADD_X6_X5  = 32'h00028333;
  localparam logic [31:0] I_BAD        = 32'h0000007F;

  de_latch_t dl;

  initial begin
    reset = 1'b0; fe_latch_in = '0; agex_flush = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    tick(); tick();
    chk("reset_latch", de_latch_out, '0);
    chk("reset_stall", DE_LATCH_W'(stall_to_fe), '0);
    reset = 1'b1;

    // first instruction
    drive(I_ADDI_X1_5, 32'h100, 32'd1);
    #2 chk("addi_nostall", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("addi_x1", de_latch_out, mk(OP_ADDI, 1'b1, 5'd1, 32'd0, 32'd0, 32'd5, 32'h100, 32'd1));

    // RAW on x1
    drive(I_ADD_X2_X1, 32'h104, 32'd2);
    #2 chk("raw_stall1", DE_LATCH_W'(stall_to_fe), DE_LATCH_W'(1'b1));
    tick();
    chk("raw_bubble1", de_latch_out, '0);
    #2 chk("raw_stall2", DE_LATCH_W'(stall_to_fe), DE_LATCH_W'(1'b1));
    tick();
    chk("raw_bubble2", de_latch_out, '0);
    wb(1'b1, 5'd1, 32'd5);
    #2 chk("raw_release", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("raw_add", de_latch_out, mk(OP_ADD, 1'b1, 5'd2, 32'd5, 32'd5, 32'd0, 32'h104, 32'd2));
    wb(1'b0, 5'd0, 32'd0);

    // reset while stalled on x2
    drive(I_ADD_X3_X2, 32'h108, 32'd3);
    #2 chk("pre_reset_stall", DE_LATCH_W'(stall_to_fe), DE_LATCH_W'(1'b1));
    reset = 1'b0;
    #1 chk("midreset_stall", DE_LATCH_W'(stall_to_fe), '0);
    chk("midreset_latch", de_latch_out, '0);
    fe_latch_in = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("post_reset_idle", de_latch_out, '0);
    drive(I_ADDI_X1_5, 32'h200, 32'd10);
    #2 chk("post_reset_nostall", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("post_reset_addi", de_latch_out, mk(OP_ADDI, 1'b1, 5'd1, 32'd0, 32'd0, 32'd5, 32'h200, 32'd10));

    // retire x1 with no valid input
    fe_latch_in = '0;
    wb(1'b1, 5'd1, 32'd5);
    tick();
    chk("invalid_bubble", de_latch_out, '0);
    wb(1'b0, 5'd0, 32'd0);

    // flush then kill, third input passes and sees sb[1]==0
    drive(I_ADDI_X1_5, 32'h204, 32'd11);
    agex_flush = 1'b1;
    #2 chk("flush_nostall", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("flush_bubble", de_latch_out, '0);
    agex_flush = 1'b0;
    drive(I_ADDI_X1_5, 32'h208, 32'd12);
    tick();
    chk("kill_bubble", de_latch_out, '0);
    drive(I_ADD_X2_X1, 32'h20C, 32'd13);
    #2 chk("after_kill_nostall", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("after_kill_add", de_latch_out, mk(OP_ADD, 1'b1, 5'd2, 32'd5, 32'd5, 32'd0, 32'h20C, 32'd13));

    // flush overrides a hazard on x2; flush during kill extends kill
    drive(I_ADD_X3_X2, 32'h210, 32'd14);
    agex_flush = 1'b1;
    #2 chk("flush_over_stall", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("flush2_bubble", de_latch_out, '0);
    drive(I_ADDI_X1_5, 32'h214, 32'd15);
    tick();
    chk("flush_in_kill_bubble", de_latch_out, '0);
    agex_flush = 1'b0;
    drive(I_ADDI_X1_5, 32'h218, 32'd16);
    tick();
    chk("kill_extended_bubble", de_latch_out, '0);

    // x0 destination
    drive(I_ADDI_X0_1, 32'h21C, 32'd17);
    tick();
    chk("addi_x0", de_latch_out, mk(OP_ADDI, 1'b0, 5'd0, 32'd0, 32'd0, 32'd1, 32'h21C, 32'd17));
    drive(I_ADD_X3_X0, 32'h220, 32'd18);
    #2 chk("x0_nostall", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("add_x0_x0", de_latch_out, mk(OP_ADD, 1'b1, 5'd3, 32'd0, 32'd0, 32'd0, 32'h220, 32'd18));

    // B-type immediate
    drive(I_BEQ_M4, 32'h224, 32'd19);
    tick();
    dl = de_latch_out;
    chk("beq_valid", DE_LATCH_W'(dl.valid), DE_LATCH_W'(1'b1));
    chk("beq_op", DE_LATCH_W'(dl.op), DE_LATCH_W'(OP_BEQ));
    chk("beq_imm", DE_LATCH_W'(dl.imm), DE_LATCH_W'(32'hFFFFFFFC));
    chk("beq_wr_en", DE_LATCH_W'(dl.wr_en), '0);

    // simultaneous inc/dec on x5 keeps sb[5]==1
    drive(I_ADDI_X5_7, 32'h228, 32'd20);
    tick();
    chk("addi_x5_7", de_latch_out, mk(OP_ADDI, 1'b1, 5'd5, 32'd0, 32'd0, 32'd7, 32'h228, 32'd20));
    drive(I_ADDI_X5_9, 32'h22C, 32'd21);
    wb(1'b1, 5'd5, 32'd7);
    #2 chk("simul_nostall", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("addi_x5_9", de_latch_out, mk(OP_ADDI, 1'b1, 5'd5, 32'd0, 32'd0, 32'd9, 32'h22C, 32'd21));
    wb(1'b0, 5'd0, 32'd0);
    drive(I_ADD_X6_X5, 32'h230, 32'd22);
    #2 chk("simul_dep_stall", DE_LATCH_W'(stall_to_fe), DE_LATCH_W'(1'b1));
    tick();
    chk("simul_dep_bubble", de_latch_out, '0);
    wb(1'b1, 5'd5, 32'd9);
    #2 chk("simul_release", DE_LATCH_W'(stall_to_fe), '0);
    tick();
    chk("simul_add", de_latch_out, mk(OP_ADD, 1'b1, 5'd6, 32'd9, 32'd0, 32'd0, 32'h230, 32'd22));
    wb(1'b0, 5'd0, 32'd0);

    // unknown opcode passes through as valid OP_INVALID
    drive(I_BAD, 32'h234, 32'd23);
    tick();
    chk("invalid_op", de_latch_out, mk(OP_INVALID, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h234, 32'd23));
    fe_latch_in = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/de_stage.md
Name: de_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes the fetch latch {valid, inst, pc, pcplus, inst_count}.
- It decodes the instruction, reads the register file (written back from WB), and detects RAW hazards with a per-register pending-write scoreboard.
- It stalls fetch on a hazard and registers a decoded bundle into the DE latch toward AGEX.
- It squashes wrong-path instructions on an AGEX redirect.

Parameters:
DBITS, 32, data/PC/instruction width
REGNO, 32, architectural register count
REGBITS, 5, register index width
SB_BITS, 2, pending-write counter width per register
FE_LATCH_W, 129, fetch latch width: valid 1 + inst 32 + pc 32 + pcplus 32 + inst_count 32
DE_LATCH_W, 205, DE latch width (field order fixed in Behaviour)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
fe_latch_in  in  FE_LATCH_W  fetch latch, MSB-first {valid, inst, pc, pcplus, inst_count}
agex_flush  in  1  AGEX resolved a taken branch/jump this cycle
wb_wr_en  in  1  WB register write
wb_wr_reg  in  REGBITS  WB destination
wb_wr_data  in  DBITS  WB data
stall_to_fe  out  1  fetch must hold PC and its latch this cycle
de_latch_out  out  DE_LATCH_W  {valid, op[5:0], wr_en, rd[4:0], rs1val, rs2val, imm, pc, pcplus, inst_count}

Behaviour:
- Reset (reset=0, async):
  - de_latch_out = all zeros; stall_to_fe = 0.
  - All scoreboard counters = 0; kill flag = 0; registers x1..x31 = 0.
  - Reset mid-stall or mid-flush discards everything; the first post-reset cycle behaves as idle.
- Latency: one cycle from fe_latch_in to de_latch_out. Decode and register read are combinational; the DE latch is registered.
- Decode:
  - op is enumerated: LUI, AUIPC, JAL, JALR, BEQ..BGEU, LW, SW, ADDI..SRAI, ADD..AND.
  - An unknown opcode gives OP_INVALID with wr_en=0. It is still passed through as valid so AGEX can trap.
  - imm uses the I/S/B/U/J format by opcode, sign-extended to 32 bits; R-type imm=0.
  - wr_en=1 only when the format writes rd and rd≠0.
- Register file: 2R1W.
  - Write is on the rising edge when wb_wr_en and wb_wr_reg≠0.
  - Reads are write-through: if wb_wr_reg matches a source in the same cycle, wb_wr_data is returned.
  - x0 always reads 0.
- Scoreboard:
  - sb[r] increments when a valid, non-squashed, non-stalled instruction with wr_en=1 is latched out with rd=r.
  - sb[r] decrements on wb_wr_en for r≠0.
  - Increment and decrement on the same r in the same cycle leave sb[r] unchanged.
  - sb[0] is constant 0.
  - Overflow past 3 or underflow below 0 is a design error: assertion, and the counter saturates.
- Hazard: hazard = input valid AND a used source rs has sb[rs]≠0 AND NOT (wb_wr_en AND wb_wr_reg==rs AND sb[rs]==1).
- Stall (hazard, no flush):
  - stall_to_fe = 1.
  - DE latch loads a bubble (valid=0, rest zero).
  - The scoreboard is not incremented.
  - The same fe_latch_in is re-evaluated the next cycle.
- Flush (agex_flush=1):
  - The current input is squashed: DE latch loads a bubble and the scoreboard is not incremented.
  - stall_to_fe = 0; flush overrides stall.
  - The kill flag is set, so the next cycle's input (fetched from the old PC at the redirect edge) is also squashed. The kill flag then clears.
- Flush while kill=1: the kill flag stays set for one more cycle.
- Input valid=0: bubble out, no stall, no scoreboard change.

Optional Feature:
- Macro DE_STALL_STATS_EN.
- When defined:
  - Adds output perf_stall_cnt (32 bits), counting cycles with stall_to_fe=1.
  - Adds output perf_squash_cnt (32 bits), counting valid inputs dropped by flush or kill.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package de_pkg:
  - op enum (6 bits), including OP_INVALID.
  - RV32I opcode/funct3/funct7 constants.
  - Field widths FE_LATCH_W and DE_LATCH_W.
  - DE latch field offsets, shared with AGEX.
- Sub-module de_regfile: 32x32, 2 read / 1 write, write-through, x0 hardwired to 0, async active-low reset.
- Scoreboard, kill flag and DE latch stay in de_stage.

Test Plan:
- Reset: drive reset=0 while a stall is active -> de_latch_out=0 and stall_to_fe=0 immediately. After release, a valid ADDI x1,x0,5 (0x00500093) appears with imm=5 and wr_en=1 one cycle later.
- RAW stall: issue 0x00500093, then ADD x2,x1,x1 (0x00108133) -> stall_to_fe=1 with bubbles out. When WB writes x1=5, the same cycle releases: rs1val=rs2val=5 and stall_to_fe=0.
- Flush: agex_flush=1 with valid input 0x00500093 -> the next two DE outputs have valid=0, sb[1] stays 0, and the third input passes through.
- x0 destination: ADDI x0,x0,1 (0x00100013) then ADD x3,x0,x0 -> no stall and rs1val=rs2val=0.
- Immediate: BEQ x0,x0,-4 (0xFE000EE3) -> op=BEQ, imm=0xFFFFFFFC, wr_en=0.
- Simultaneous: sb[5]=1, WB writes x5 while a new ADDI x5 is latched out -> sb[5] remains 1. A dependent instruction the next cycle stalls.
